mem_bist_initiator: RTL and testbench

- Initiator (master) for the single-port memory valid/ready interface: wr_rd, addr, wdata, valid out; ready, rdata in.
- On a start command it writes a deterministic pattern over a programmable address window, then reads the window back and compares.
- Reports pass/fail, first failing address and error count.
- Sits between the test/control logic and the memory instance; it replaces hand-written bench stimulus as the hardware self-test front end.

---
 rtl/mem_bist_initiator.sv | 190 +++++++++++++++++++
 tb/tb_mem_bist_initiator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_initiator.sv
// Self-test master for a single-port valid/ready memory: writes a seed^address pattern over a window, reads it back, reports the result.
// Define MEM_BIST_INV_PASS_EN to add a second write/read sweep using the inverted pattern.
module mem_bist_initiator #(
   parameter int MEMORY_WIDTH  = 8,
   parameter int MEMORY_DEPTH  = 16,
   parameter int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [ADDRESS_WIDTH-1:0] start_addr_i,
   input  logic [ADDRESS_WIDTH:0]   num_locations_i,
   input  logic [MEMORY_WIDTH-1:0]  seed_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     pass_o,
   output logic [ADDRESS_WIDTH-1:0] fail_addr_o,
   output logic [ADDRESS_WIDTH:0]   err_count_o,
   output logic                     valid_o,
   output logic                     wr_rd_o,
   output logic [ADDRESS_WIDTH-1:0] addr_o,
   output logic [MEMORY_WIDTH-1:0]  wdata_o,
   input  logic                     ready_i,
   input  logic [MEMORY_WIDTH-1:0]  rdata_i
);

   typedef enum logic [2:0] {
      IDLE, WRITE, READ, DONE
`ifdef MEM_BIST_INV_PASS_EN
      , WRITE_INV, READ_INV
`endif
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
   localparam logic [ADDRESS_WIDTH:0]   DEPTH_N   = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);
   localparam logic [ADDRESS_WIDTH:0]   CNT_ONE   = (ADDRESS_WIDTH + 1)'(1);

   state_t                   state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] base, base_nxt;
   logic [ADDRESS_WIDTH:0]   len, len_nxt, k, k_nxt, win;
   logic [MEMORY_WIDTH-1:0]  seed, seed_nxt;
   logic                     valid_nxt, wr_rd_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [ADDRESS_WIDTH-1:0] addr_nxt, fail_addr_nxt;
   logic [MEMORY_WIDTH-1:0]  wdata_nxt;
   logic [ADDRESS_WIDTH:0]   err_nxt;
   logic                     xfer, last, mismatch;

   function automatic logic is_write(input state_t s);
`ifdef MEM_BIST_INV_PASS_EN
      return (s == WRITE) || (s == WRITE_INV);
`else
      return s == WRITE;
`endif
   endfunction

   function automatic logic is_read(input state_t s);
`ifdef MEM_BIST_INV_PASS_EN
      return (s == READ) || (s == READ_INV);
`else
      return s == READ;
`endif
   endfunction

   function automatic logic is_inv(input state_t s);
`ifdef MEM_BIST_INV_PASS_EN
      return (s == WRITE_INV) || (s == READ_INV);
`else
      return (s != s);
`endif
   endfunction

   // Window addresses wrap from the top of the memory back to 0.
   function automatic logic [ADDRESS_WIDTH-1:0] next_addr(input logic [ADDRESS_WIDTH-1:0] a);
      if (a == LAST_ADDR) return '0;
      else return a + ADDR_ONE;
   endfunction

   function automatic logic [MEMORY_WIDTH-1:0] pattern(input logic [ADDRESS_WIDTH-1:0] a,
                                                       input logic [MEMORY_WIDTH-1:0] s,
                                                       input logic invert);
      logic [MEMORY_WIDTH-1:0] p;
      p = s ^ MEMORY_WIDTH'(a);
      return invert ? ~p : p;
   endfunction

   // A transfer completes on any cycle with valid_o && ready_i; while it waits,
   // valid_o, wr_rd_o, addr_o and wdata_o are held because nothing below moves without xfer.
   assign xfer     = valid_o & ready_i;
   assign last     = (k + CNT_ONE) == len;
   assign win      = (num_locations_i > DEPTH_N) ? DEPTH_N : num_locations_i;
   assign mismatch = rdata_i != pattern(addr_o, seed, is_inv(state));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start_i) state_nxt = (win == '0) ? DONE : WRITE;
         WRITE:     if (xfer && last) state_nxt = READ;
`ifdef MEM_BIST_INV_PASS_EN
         READ:      if (xfer && last) state_nxt = WRITE_INV;
         WRITE_INV: if (xfer && last) state_nxt = READ_INV;
         READ_INV:  if (xfer && last) state_nxt = DONE;
`else
         READ:      if (xfer && last) state_nxt = DONE;
`endif
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      base_nxt      = base;
      len_nxt       = len;
      seed_nxt      = seed;
      k_nxt         = k;
      valid_nxt     = valid_o;
      wr_rd_nxt     = wr_rd_o;
      addr_nxt      = addr_o;
      wdata_nxt     = wdata_o;
      pass_nxt      = pass_o;
      fail_addr_nxt = fail_addr_o;
      err_nxt       = err_count_o;
      busy_nxt      = state_nxt != IDLE;
      done_nxt      = state_nxt == DONE;
      if (state == IDLE && start_i) begin
         base_nxt      = start_addr_i;
         len_nxt       = win;
         seed_nxt      = seed_i;
         pass_nxt      = 1'b1;
         fail_addr_nxt = '0;
         err_nxt       = '0;
      end
      // pass_o still high means no earlier mismatch in this test.
      if (is_read(state) && xfer && mismatch) begin
         if (pass_o) fail_addr_nxt = addr_o;
         pass_nxt = 1'b0;
         if (err_count_o != '1) err_nxt = err_count_o + CNT_ONE;
      end
      if (xfer && !last) begin
         k_nxt     = k + CNT_ONE;
         addr_nxt  = next_addr(addr_o);
         wdata_nxt = is_write(state) ? pattern(next_addr(addr_o), seed, is_inv(state)) : '0;
      end
      if (state_nxt != state) begin
         k_nxt     = '0;
         valid_nxt = is_write(state_nxt) || is_read(state_nxt);
         wr_rd_nxt = is_write(state_nxt);
         addr_nxt  = (is_write(state_nxt) || is_read(state_nxt)) ? base_nxt : '0;
         wdata_nxt = is_write(state_nxt) ? pattern(base_nxt, seed_nxt, is_inv(state_nxt)) : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         base        <= '0;
         len         <= '0;
         seed        <= '0;
         k           <= '0;
         valid_o     <= 1'b0;
         wr_rd_o     <= 1'b0;
         addr_o      <= '0;
         wdata_o     <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         pass_o      <= 1'b1;
         fail_addr_o <= '0;
         err_count_o <= '0;
      end else begin
         base        <= base_nxt;
         len         <= len_nxt;
         seed        <= seed_nxt;
         k           <= k_nxt;
         valid_o     <= valid_nxt;
         wr_rd_o     <= wr_rd_nxt;
         addr_o      <= addr_nxt;
         wdata_o     <= wdata_nxt;
         busy_o      <= busy_nxt;
         done_o      <= done_nxt;
         pass_o      <= pass_nxt;
         fail_addr_o <= fail_addr_nxt;
         err_count_o <= err_nxt;
      end
   end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Table-driven bench for mem_bist_initiator with an ideal/faulty memory model and optional back-pressure.
module tb_mem_bist_initiator;
   localparam int MW = 8;
   localparam int MD = 16;
   localparam int AW = 4;
   localparam int XW = 1 + AW + MW;
`ifdef MEM_BIST_INV_PASS_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif

   logic          clk_i, rst_i, start_i;
   logic [AW-1:0] start_addr_i;
   logic [AW:0]   num_locations_i;
   logic [MW-1:0] seed_i;
   logic          busy_o, done_o, pass_o, valid_o, wr_rd_o, ready_i;
   logic [AW-1:0] fail_addr_o, addr_o;
   logic [AW:0]   err_count_o;
   logic [MW-1:0] wdata_o, rdata_i;

   mem_bist_initiator dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .start_addr_i(start_addr_i),
      .num_locations_i(num_locations_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
      .pass_o(pass_o), .fail_addr_o(fail_addr_o), .err_count_o(err_count_o), .valid_o(valid_o),
      .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wdata_o(wdata_o), .ready_i(ready_i), .rdata_i(rdata_i)
   );

   // clock / reset
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endfunction

   // memory model: ready stalls 3 cycles per transfer when stall_en; fault modes corrupt reads
   logic [MW-1:0] mem [MD];
   int            wait_cnt;
   bit            stall_en;
   int            fault_mode;
   logic [AW-1:0] fault_addr;

   assign ready_i = !stall_en || (wait_cnt == 3);

   always @(posedge clk_i) begin
      if (!rst_i) wait_cnt <= 0;
      else if (valid_o && ready_i) begin
         wait_cnt <= 0;
         if (wr_rd_o) mem[addr_o] <= wdata_o;
      end else if (valid_o) wait_cnt <= wait_cnt + 1;
   end

   always_comb begin
      rdata_i = mem[addr_o];
      if (fault_mode == 1 && addr_o == fault_addr) rdata_i[0] = 1'b0;
      if (fault_mode == 2) rdata_i = ~mem[addr_o];
   end

   // scoreboard: expected {wr_rd, addr, wdata} per transfer, plus hold-while-stalled check
   logic [XW-1:0] exp_q[$];
   logic [XW-1:0] held;
   bit            stalled;
   int            valid_cycles;

   always @(negedge clk_i) begin
      if (rst_i) begin
         if (stalled) check("stall_hold", {valid_o, wr_rd_o, addr_o, wdata_o}, {1'b1, held});
         if (valid_o) valid_cycles <= valid_cycles + 1;
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL xfer_extra: got %h, expected no transfer", {wr_rd_o, addr_o, wdata_o});
            end else check("xfer", {wr_rd_o, addr_o, wdata_o}, exp_q.pop_front());
         end
         stalled <= valid_o && !ready_i;
         held    <= {wr_rd_o, addr_o, wdata_o};
      end else stalled <= 1'b0;
   end

   typedef struct packed {
      logic [AW-1:0] start_addr;
      logic [AW:0]   num;
      logic [MW-1:0] seed;
      int            fault_mode;
      logic [AW-1:0] fault_addr;
      bit            stall;
      bit            poke;
      bit            exp_pass;
      logic [AW-1:0] exp_fail_addr;
      int            exp_err;
      int            exp_err_inv;
      int            exp_busy;
   } vec_t;

   vec_t vecs[7];

   task automatic build_exp(input logic [AW-1:0] sa, input int n, input logic [MW-1:0] seed);
      logic [AW-1:0] a;
      logic [MW-1:0] d;
      exp_q.delete();
      for (int p = 0; p < PASSES; p++) begin
         for (int k = 0; k < n; k++) begin
            a = sa + AW'(k);
            d = seed ^ {4'b0000, a};
            if (p == 1) d = ~d;
            exp_q.push_back({1'b1, a, d});
         end
         for (int k = 0; k < n; k++) begin
            a = sa + AW'(k);
            exp_q.push_back({1'b0, a, 8'h00});
         end
      end
   endtask

   // driver: one start pulse, then follow busy_o to completion and check results
   task automatic run_test(input vec_t v, input string tag);
      int n, busy_cnt, done_cnt, done_at, guard, v0, exp_busy, exp_err;
      n        = (v.num > 5'd16) ? 16 : int'(v.num);
      exp_busy = (PASSES == 2) ? (v.exp_busy - 1) * 2 + 1 : v.exp_busy;
      exp_err  = (PASSES == 2) ? v.exp_err_inv : v.exp_err;
      build_exp(v.start_addr, n, v.seed);
      stall_en   = v.stall;
      fault_mode = v.fault_mode;
      fault_addr = v.fault_addr;
      @(negedge clk_i);
      start_addr_i    = v.start_addr;
      num_locations_i = v.num;
      seed_i          = v.seed;
      start_i         = 1'b1;
      v0              = valid_cycles;
      @(negedge clk_i);
      start_i  = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = 0;
      guard    = 0;
      while (busy_o && guard < 1000) begin
         busy_cnt++;
         if (done_o) begin
            done_cnt++;
            done_at = busy_cnt;
         end
         if (v.poke && (busy_cnt == 2 || done_o)) begin
            start_i         = 1'b1;
            start_addr_i    = 4'd9;
            num_locations_i = 5'd5;
         end else start_i = 1'b0;
         @(negedge clk_i);
         guard++;
      end
      start_i = 1'b0;
      check($sformatf("%s_timeout", tag), guard < 1000, 1);
      check($sformatf("%s_busy_cycles", tag), busy_cnt, exp_busy);
      check($sformatf("%s_done_pulses", tag), done_cnt, 1);
      check($sformatf("%s_done_cycle", tag), done_at, exp_busy);
      check($sformatf("%s_valid_cycles", tag), valid_cycles - v0, exp_busy - 1);
      check($sformatf("%s_left_in_queue", tag), exp_q.size(), 0);
      check($sformatf("%s_pass", tag), pass_o, v.exp_pass);
      check($sformatf("%s_fail_addr", tag), fail_addr_o, v.exp_fail_addr);
      check($sformatf("%s_err_count", tag), err_count_o, exp_err);
      exp_q.delete();
   endtask

   initial begin
      int   guard;
      vec_t vpoke;
      rst_i = 1'b0; start_i = 1'b0; start_addr_i = '0; num_locations_i = '0; seed_i = '0;
      stall_en = 1'b0; fault_mode = 0; fault_addr = '0; valid_cycles = 0;

      //          sa     num     seed   fm fa    st    pk    pass  fa    err ei  busy
      vecs[0] = '{4'd0,  5'd16, 8'hA5, 0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 0,  0,  33};
      vecs[1] = '{4'd14, 5'd4,  8'h00, 0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 0,  0,  9};
      vecs[2] = '{4'd2,  5'd4,  8'h5A, 0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 0,  0,  33};
      vecs[3] = '{4'd0,  5'd16, 8'h00, 1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd5, 1,  1,  33};
      vecs[4] = '{4'd0,  5'd0,  8'h33, 0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 0,  0,  1};
      vecs[5] = '{4'd7,  5'd1,  8'hF0, 0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 0,  0,  9};
      vecs[6] = '{4'd9,  5'd20, 8'h81, 2, 4'd0, 1'b0, 1'b0, 1'b0, 4'd9, 16, 31, 33};
      vpoke   = '{4'd3,  5'd2,  8'h3C, 0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 0,  0,  5};

      repeat (3) @(negedge clk_i);
      check("rst_valid", valid_o, 0);
      check("rst_wr_rd", wr_rd_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_addr", addr_o, 0);
      check("rst_wdata", wdata_o, 0);
      check("rst_fail_addr", fail_addr_o, 0);
      check("rst_err", err_count_o, 0);
      check("rst_pass", pass_o, 1);
      rst_i = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < 7; i++) run_test(vecs[i], $sformatf("vec%0d", i));

      // reset while writing address 7 aborts with no done pulse
      build_exp(4'd0, 16, 8'h00);
      stall_en = 1'b0; fault_mode = 0;
      @(negedge clk_i);
      start_addr_i = 4'd0; num_locations_i = 5'd16; seed_i = 8'h00; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      guard = 0;
      while (!(valid_o && wr_rd_o && addr_o == 4'd7) && guard < 100) begin
         @(negedge clk_i);
         guard++;
      end
      check("abort_reach_addr7", addr_o, 7);
      #2 rst_i = 1'b0;
      #1;
      check("abort_valid", valid_o, 0);
      check("abort_busy", busy_o, 0);
      check("abort_done", done_o, 0);
      check("abort_pass", pass_o, 1);
      check("abort_err", err_count_o, 0);
      check("abort_fail_addr", fail_addr_o, 0);
      exp_q.delete();
      @(negedge clk_i);
      check("abort_done_later", done_o, 0);
      check("abort_busy_later", busy_o, 0);
      rst_i = 1'b1;
      @(negedge clk_i);
      run_test(vpoke, "after_abort");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
